// File: rtl/button_cond.sv
// ============================================================================
//  Module   : button_cond
//  Purpose  : Input conditioning for the four cursor push-buttons that feed
//             DataGen. Each raw pin is synchronised (2 FF), debounced, and
//             turned into a registered single-cycle press strobe. Opposing
//             buttons (up/down, left/right) that strobe on the same edge
//             cancel each other.
//  Macro    : BUTTON_REPEAT_EN - when defined, a held button also emits
//             auto-repeat strobes (REPEAT_DELAY after the press strobe, then
//             every REPEAT_PERIOD cycles).
//  Ports    : i_clk            - clock, rising edge
//             i_rst            - asynchronous active-high reset
//             i_btn_up/down/left/right     - raw button levels, 1 = pressed
//             o_buffon_up/down/left/right  - one-cycle press strobes
//             o_held[3:0]      - debounced levels {up, down, left, right}
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_cond #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_btn_left,
   input  logic       i_btn_right,
   output logic       o_buffon_up,
   output logic       o_buffon_down,
   output logic       o_buffon_left,
   output logic       o_buffon_right,
   output logic [3:0] o_held
);

   localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bit order everywhere: 3 = up, 2 = down, 1 = left, 0 = right.
   logic [3:0] raw;
   logic [3:0] db;
   logic [3:0] cand;
   logic [3:0] pulse;

   assign raw = {i_btn_up, i_btn_down, i_btn_left, i_btn_right};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      logic             s1;
      logic             s2;
      logic             db_q;
      logic [CNT_W-1:0] cnt;
      logic             accept;
      logic             rise;
      logic             fall;
      logic             rep;

      // Level change is accepted on the edge where the counter has seen
      // DEBOUNCE_CYCLES-1 prior mismatching cycles and the mismatch persists.
      assign accept = (s2 != db_q) && (cnt == CNT_LAST);
      assign rise   = accept &  s2;
      assign fall   = accept & ~s2;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db_q <= 1'b0;
            cnt  <= '0;
         end else begin
            s1 <= raw[g];
            s2 <= s1;
            if (s2 == db_q) begin
               cnt <= '0;
            end else if (accept) begin
               db_q <= s2;
               cnt  <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end

`ifdef BUTTON_REPEAT_EN
      localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

      logic [RPT_W-1:0] rcnt;
      logic             rphase;   // 0: waiting for first repeat, 1: periodic
      logic [RPT_W-1:0] rlast;

      assign rlast = rphase ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
      // No repeat on the edge where the button is being released.
      assign rep   = db_q & ~fall & (rcnt == rlast);

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            rcnt   <= '0;
            rphase <= 1'b0;
         end else if (rise || !db_q || fall) begin
            rcnt   <= '0;
            rphase <= 1'b0;
         end else if (rep) begin
            // Timer restarts even if the strobe is cancelled downstream.
            rcnt   <= '0;
            rphase <= 1'b1;
         end else begin
            rcnt <= rcnt + RPT_W'(1);
         end
      end
`else
      assign rep = 1'b0;
`endif

      assign db[g]   = db_q;
      assign cand[g] = rise | rep;
   end : g_btn

`ifndef BUTTON_REPEAT_EN
   // Repeat timing has no effect in this build; referenced only here.
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_params_unused
   end
`endif

   // Opposing pairs that fire together cancel each other.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pulse <= 4'b0000;
      end else begin
         pulse <= {cand[3] & ~cand[2],
                   cand[2] & ~cand[3],
                   cand[1] & ~cand[0],
                   cand[0] & ~cand[1]};
      end
   end

   assign o_buffon_up    = pulse[3];
   assign o_buffon_down  = pulse[2];
   assign o_buffon_left  = pulse[1];
   assign o_buffon_right = pulse[0];
   assign o_held         = db;

endmodule

`default_nettype wire
